// File: rtl/multdiv_controller_pkg.sv
// Shared definitions for the mult/div sequencer: state encodings, default cycle
// counts and request decoding used by the controller and its counter.
package multdiv_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MULT = 2'd1,
      ST_DIV  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam int DEF_MULT_CYCLES = 32;
   localparam int DEF_DIV_CYCLES  = 33;
   localparam int DEF_CNT_W       = 6;

   typedef struct packed {
      logic start_mult;
      logic start_div;
      logic div_by_zero;
      logic illegal;
   } request_t;

   // Classifies the request lines; only meaningful while the controller is accepting.
   function automatic request_t decode_request(input logic mult_req,
                                               input logic div_req,
                                               input logic [15:0] divisor);
      request_t r;
      r.illegal     = mult_req & div_req;
      r.start_mult  = mult_req & ~div_req;
      r.div_by_zero = div_req & ~mult_req & (divisor == 16'd0);
      r.start_div   = div_req & ~mult_req & (divisor != 16'd0);
      return r;
   endfunction

endpackage

// File: rtl/multdiv_cycle_counter.sv
// Loadable down counter that times how long operands are held stable to a datapath.
module multdiv_cycle_counter #(
   parameter int CNT_W = 6
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] value,
   input  logic             enable,
   output logic             zero
);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         count <= '0;
      end else if (load) begin
         count <= value;
      end else if (enable && (count != '0)) begin
         count <= count - 1'b1;
      end
   end

   assign zero = (count == '0);

endmodule

// File: rtl/multdiv_controller.sv
// Sequencer sharing one multi-cycle multiplier and one divider behind a single
// request interface; latches operands, times the operation and captures the result.
module multdiv_controller
   import multdiv_controller_pkg::*;
#(
   parameter int MULT_CYCLES = DEF_MULT_CYCLES,
   parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        ctrl_MULT,
   input  logic        ctrl_DIV,
   input  logic [31:0] data_operandA,
   input  logic [31:0] data_operandB,
   output logic [31:0] mult_operandA,
   output logic [31:0] mult_operandB,
   output logic [31:0] div_operandA,
   output logic [15:0] div_operandB,
   input  logic [31:0] mult_result,
   input  logic        mult_exception,
   input  logic [31:0] div_result,
   input  logic        div_exception,
   output logic [31:0] data_result,
   output logic        data_exception,
   output logic        data_inputRDY,
   output logic        data_resultRDY
);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

   state_t           state;
   state_t           state_next;
   request_t         req;
   logic             accepting;
   logic             cnt_load;
   logic [CNT_W-1:0] cnt_value;
   logic             cnt_enable;
   logic             cnt_zero;
   logic             load_mult_ops;
   logic             load_div_ops;
   logic             capture_mult;
   logic             capture_div;
   logic             capture_error;

   assign req = decode_request(ctrl_MULT, ctrl_DIV, data_operandB[15:0]);

   multdiv_cycle_counter #(
      .CNT_W (CNT_W)
   ) u_counter (
      .clock   (clock),
      .reset_n (reset_n),
      .load    (cnt_load),
      .value   (cnt_value),
      .enable  (cnt_enable),
      .zero    (cnt_zero)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (req.illegal || req.div_by_zero) begin
               state_next = ST_DONE;
            end else if (req.start_mult) begin
               state_next = ST_MULT;
            end else if (req.start_div) begin
               state_next = ST_DIV;
            end else begin
               state_next = ST_IDLE;
            end
         end
         ST_MULT, ST_DIV: begin
            if (cnt_zero) begin
               state_next = ST_DONE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      accepting      = (state == ST_IDLE) || (state == ST_DONE);
      data_inputRDY  = accepting;
      data_resultRDY = (state == ST_DONE);
      cnt_enable     = (state == ST_MULT) || (state == ST_DIV);
      load_mult_ops  = accepting && req.start_mult;
      // A zero divisor is still an accepted divide, so its operands are latched too.
      load_div_ops   = accepting && (req.start_div || req.div_by_zero);
      cnt_load       = accepting && (req.start_mult || req.start_div);
      cnt_value      = req.start_mult ? MULT_LOAD : DIV_LOAD;
      capture_mult   = (state == ST_MULT) && cnt_zero;
      capture_div    = (state == ST_DIV) && cnt_zero;
      capture_error  = accepting && (req.illegal || req.div_by_zero);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mult_operandA <= '0;
         mult_operandB <= '0;
      end else if (load_mult_ops) begin
         mult_operandA <= data_operandA;
         mult_operandB <= data_operandB;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         div_operandA <= '0;
         div_operandB <= '0;
      end else if (load_div_ops) begin
         div_operandA <= data_operandA;
         div_operandB <= data_operandB[15:0];
      end
   end

   // Result stays put across back-to-back requests until the new op finishes.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_result    <= '0;
         data_exception <= 1'b0;
      end else if (capture_mult) begin
         data_result    <= mult_result;
         data_exception <= mult_exception;
      end else if (capture_div) begin
         data_result    <= div_result;
         data_exception <= div_exception;
      end else if (capture_error) begin
         data_result    <= '0;
         data_exception <= 1'b1;
      end
   end

endmodule

// File: tb/tb_multdiv_controller.sv
// Directed bench for multdiv_controller with stubbed mult/div datapath results.
module tb_multdiv_controller;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        ctrl_MULT = 1'b0;
   logic        ctrl_DIV = 1'b0;
   logic [31:0] data_operandA = '0;
   logic [31:0] data_operandB = '0;
   logic [31:0] mult_operandA;
   logic [31:0] mult_operandB;
   logic [31:0] div_operandA;
   logic [15:0] div_operandB;
   logic [31:0] mult_result = '0;
   logic        mult_exception = 1'b0;
   logic [31:0] div_result = '0;
   logic        div_exception = 1'b0;
   logic [31:0] data_result;
   logic        data_exception;
   logic        data_inputRDY;
   logic        data_resultRDY;

   int errors = 0;
   int checks = 0;
   int pulses;

   multdiv_controller dut (
      .clock          (clock),
      .reset_n        (reset_n),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .mult_operandA  (mult_operandA),
      .mult_operandB  (mult_operandB),
      .div_operandA   (div_operandA),
      .div_operandB   (div_operandB),
      .mult_result    (mult_result),
      .mult_exception (mult_exception),
      .div_result     (div_result),
      .div_exception  (div_exception),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_inputRDY  (data_inputRDY),
      .data_resultRDY (data_resultRDY)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to the next cycle, sampling 1 time unit after the rising edge.
   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      #3;
      chk("rst_result", data_result, 32'd0);
      chk("rst_exc", {31'd0, data_exception}, 32'd0);
      chk("rst_inrdy", {31'd0, data_inputRDY}, 32'd1);
      chk("rst_resrdy", {31'd0, data_resultRDY}, 32'd0);
      chk("rst_mopa", mult_operandA, 32'd0);
      chk("rst_dopb", {16'd0, div_operandB}, 32'd0);
      step();
      reset_n = 1'b1;
      step();

      // 1: multiply 7*6, result expected in cycle 33
      data_operandA = 32'd7; data_operandB = 32'd6; mult_result = 32'd42;
      ctrl_MULT = 1'b1;
      chk("t1_inrdy_c0", {31'd0, data_inputRDY}, 32'd1);
      step();
      ctrl_MULT = 1'b0;
      data_operandA = 32'hDEAD_BEEF; data_operandB = 32'hCAFE_0000;
      for (int c = 1; c <= 32; c++) begin
         chk("t1_inrdy_busy", {31'd0, data_inputRDY}, 32'd0);
         chk("t1_resrdy_busy", {31'd0, data_resultRDY}, 32'd0);
         chk("t1_mopa_hold", mult_operandA, 32'd7);
         if (c < 32) step();
      end
      step();
      chk("t1_resrdy_c33", {31'd0, data_resultRDY}, 32'd1);
      chk("t1_result", data_result, 32'd42);
      chk("t1_exc", {31'd0, data_exception}, 32'd0);
      chk("t1_mopb", mult_operandB, 32'd6);
      $display("mult 7*6 -> result=%0d exc=%0b", data_result, data_exception);
      step();
      chk("t1_resrdy_c34", {31'd0, data_resultRDY}, 32'd0);
      chk("t1_result_held", data_result, 32'd42);

      // 2: divide -100/7, result expected in cycle 34
      data_operandA = 32'hFFFF_FF9C; data_operandB = 32'd7; div_result = 32'hFFFF_FFF2;
      ctrl_DIV = 1'b1;
      step();
      ctrl_DIV = 1'b0;
      data_operandA = 32'h1234_5678; data_operandB = 32'h0000_0000;
      for (int c = 1; c <= 33; c++) begin
         chk("t2_dopb_hold", {16'd0, div_operandB}, 32'h0000_0007);
         chk("t2_resrdy_busy", {31'd0, data_resultRDY}, 32'd0);
         if (c < 33) step();
      end
      chk("t2_dopa", div_operandA, 32'hFFFF_FF9C);
      chk("t2_mopa_frozen", mult_operandA, 32'd7);
      step();
      chk("t2_resrdy_c34", {31'd0, data_resultRDY}, 32'd1);
      chk("t2_result", data_result, 32'hFFFF_FFF2);
      chk("t2_exc", {31'd0, data_exception}, 32'd0);
      $display("div -100/7 -> result=%h exc=%0b", data_result, data_exception);
      step();

      // 3: divide by zero completes immediately
      data_operandA = 32'd5; data_operandB = 32'd0; div_result = 32'h5555_5555;
      ctrl_DIV = 1'b1;
      step();
      ctrl_DIV = 1'b0;
      chk("t3_resrdy_c1", {31'd0, data_resultRDY}, 32'd1);
      chk("t3_result", data_result, 32'd0);
      chk("t3_exc", {31'd0, data_exception}, 32'd1);
      chk("t3_inrdy_c1", {31'd0, data_inputRDY}, 32'd1);
      $display("div 5/0 -> result=%h exc=%0b", data_result, data_exception);
      step();
      chk("t3_resrdy_c2", {31'd0, data_resultRDY}, 32'd0);

      // 4: divide request during a multiply is ignored
      data_operandA = 32'd9; data_operandB = 32'd3; mult_result = 32'd27;
      ctrl_MULT = 1'b1;
      step();
      ctrl_MULT = 1'b0;
      for (int c = 1; c <= 32; c++) begin
         if (c == 5) begin
            ctrl_DIV = 1'b1; data_operandA = 32'd123; data_operandB = 32'd4;
         end else begin
            ctrl_DIV = 1'b0;
         end
         chk("t4_resrdy_busy", {31'd0, data_resultRDY}, 32'd0);
         if (c == 6) chk("t4_inrdy_c6", {31'd0, data_inputRDY}, 32'd0);
         if (c < 32) step();
      end
      ctrl_DIV = 1'b0;
      step();
      chk("t4_resrdy_c33", {31'd0, data_resultRDY}, 32'd1);
      chk("t4_result", data_result, 32'd27);
      chk("t4_dopa_frozen", div_operandA, 32'd5);
      chk("t4_mopa", mult_operandA, 32'd9);
      $display("mult 9*3 with busy div -> result=%0d", data_result);
      step();

      // 5: simultaneous requests, then back-to-back multiply in DONE
      data_operandA = 32'd77; data_operandB = 32'd88;
      ctrl_MULT = 1'b1; ctrl_DIV = 1'b1;
      step();
      ctrl_DIV = 1'b0;
      chk("t5_resrdy_c1", {31'd0, data_resultRDY}, 32'd1);
      chk("t5_exc", {31'd0, data_exception}, 32'd1);
      chk("t5_result", data_result, 32'd0);
      chk("t5_mopa_keep", mult_operandA, 32'd9);
      chk("t5_dopa_keep", div_operandA, 32'd5);
      $display("mult+div illegal -> result=%h exc=%0b", data_result, data_exception);
      data_operandA = 32'd11; data_operandB = 32'd2; mult_result = 32'd22;
      step();
      ctrl_MULT = 1'b0;
      for (int c = 2; c <= 33; c++) begin
         chk("t5_resrdy_busy", {31'd0, data_resultRDY}, 32'd0);
         chk("t5_result_old", data_result, 32'd0);
         if (c < 33) step();
      end
      step();
      chk("t5_resrdy_c34", {31'd0, data_resultRDY}, 32'd1);
      chk("t5_b2b_result", data_result, 32'd22);
      chk("t5_b2b_exc", {31'd0, data_exception}, 32'd0);
      $display("back-to-back mult 11*2 -> result=%0d", data_result);
      step();

      // 6: reset in the middle of a divide
      data_operandA = 32'd1000; data_operandB = 32'd10; div_result = 32'd100;
      ctrl_DIV = 1'b1;
      step();
      ctrl_DIV = 1'b0;
      for (int c = 1; c < 10; c++) step();
      reset_n = 1'b0;
      #2;
      chk("t6_rst_result", data_result, 32'd0);
      chk("t6_rst_inrdy", {31'd0, data_inputRDY}, 32'd1);
      chk("t6_rst_resrdy", {31'd0, data_resultRDY}, 32'd0);
      chk("t6_rst_dopa", div_operandA, 32'd0);
      step();
      reset_n = 1'b1;
      pulses = 0;
      for (int c = 0; c < 40; c++) begin
         step();
         if (data_resultRDY) pulses++;
      end
      chk("t6_no_pulse", pulses, 32'd0);
      chk("t6_inrdy_end", {31'd0, data_inputRDY}, 32'd1);
      $display("reset mid-div -> pulses after release=%0d", pulses);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
